wb_select_stage: RTL

- Registered, parametrised writeback-select stage for the register file. It picks the register write value from NUM_SRC same-cycle datapath lanes (ALU result, immediate, PC link, ...) or from a variable-latency memory read.
- Sits between the execute/memory stages and the register file write port.
- Generalises the 2:1 combinational writeback mux in three ways: N sources, a valid/ready handshake, and a wait-for-memory state machine.
- Also provides zero-register write suppression and flush.

---
 rtl/wb_select_stage.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/wb_select_stage.sv
// Registered writeback-select stage: picks the register-file write value from one
// of NUM_SRC same-cycle lanes or a variable-latency memory read. Optional feature:
// WB_TIMEOUT_EN aborts a memory wait after TIMEOUT_CYC cycles without read data.

// One lane's contribution to the select mux: passes the lane only when selected,
// so the lanes can simply be OR-combined.
module wb_select_lane #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 3,
    parameter int LANE   = 0
) (
    input  logic [SEL_W-1:0]  sel_i,
    input  logic [DATA_W-1:0] lane_i,
    output logic [DATA_W-1:0] gated_o
);
    assign gated_o = (sel_i == SEL_W'(LANE)) ? lane_i : '0;
endmodule

module wb_select_stage #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int NUM_SRC     = 4,
    parameter int ZERO_REG    = 1,
    parameter int TIMEOUT_CYC = 16,
    localparam int SEL_W      = $clog2(NUM_SRC + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic [NUM_SRC*DATA_W-1:0] in_src,
    input  logic [ADDR_W-1:0]         in_rd,
    input  logic                      in_wen,
    input  logic                      mem_rvalid,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata,
    output logic                      busy,
    output logic                      sel_err,
    output logic                      timeout
);
    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t                            state_q, state_d;
    logic                              we_q, we_d;
    logic [ADDR_W-1:0]                 waddr_q, waddr_d;
    logic [DATA_W-1:0]                 wdata_q, wdata_d;
    logic [ADDR_W-1:0]                 rd_q, rd_d;
    logic                              wen_q, wen_d;
    logic                              err_q, err_d;
    logic [NUM_SRC-1:0][DATA_W-1:0]    gated;
    logic [DATA_W-1:0]                 lane_data;
    logic                              accept;
    logic                              lane_sel, mem_sel;

    genvar k;
    generate
        for (k = 0; k < NUM_SRC; k++) begin : g_lane
            wb_select_lane #(.DATA_W(DATA_W), .SEL_W(SEL_W), .LANE(k)) u_lane (
                .sel_i   (in_sel),
                .lane_i  (in_src[k*DATA_W +: DATA_W]),
                .gated_o (gated[k])
            );
        end
    endgenerate

    always_comb begin
        lane_data = '0;
        for (int i = 0; i < NUM_SRC; i++) lane_data = lane_data | gated[i];
    end

    function automatic logic wr_ok(input logic wen, input logic [ADDR_W-1:0] rd);
        return wen && !((ZERO_REG != 0) && (rd == '0));
    endfunction

    assign in_ready = (state_q == IDLE) && !flush;
    assign accept   = in_valid && in_ready;
    assign lane_sel = (in_sel <  SEL_W'(NUM_SRC));
    assign mem_sel  = (in_sel == SEL_W'(NUM_SRC));
    assign busy     = (state_q == WAIT_MEM);
    assign rf_we    = we_q;
    assign rf_waddr = waddr_q;
    assign rf_wdata = wdata_q;
    assign sel_err  = err_q;

`ifdef WB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;
    logic             expire;

    // The wait cycle that would bring the count to TIMEOUT_CYC is the expiry cycle.
    assign expire  = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign timeout = to_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end
`else
    logic expire;
    assign expire  = 1'b0;
    // Constant 0; written against the parameter so it is referenced in this build.
    assign timeout = (TIMEOUT_CYC < 0);
`endif

    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wen_d   = wen_q;
        err_d   = err_q;
`ifdef WB_TIMEOUT_EN
        cnt_d   = cnt_q;
        to_d    = 1'b0;
`endif
        if (flush) begin
            state_d = IDLE;
`ifdef WB_TIMEOUT_EN
            cnt_d   = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (lane_sel) begin
                            if (wr_ok(in_wen, in_rd)) begin
                                we_d    = 1'b1;
                                waddr_d = in_rd;
                                wdata_d = lane_data;
                            end
                        end else if (mem_sel) begin
                            state_d = WAIT_MEM;
                            rd_d    = in_rd;
                            wen_d   = in_wen;
`ifdef WB_TIMEOUT_EN
                            cnt_d   = '0;
`endif
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (mem_rvalid) begin
                        state_d = IDLE;
                        if (wr_ok(wen_q, rd_q)) begin
                            we_d    = 1'b1;
                            waddr_d = rd_q;
                            wdata_d = mem_rdata;
                        end
                    end else if (expire) begin
                        state_d = IDLE;
`ifdef WB_TIMEOUT_EN
                        to_d    = 1'b1;
                        cnt_d   = '0;
`endif
                    end else begin
`ifdef WB_TIMEOUT_EN
                        cnt_d = cnt_q + 1'b1;
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            wen_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wen_q   <= wen_d;
            err_q   <= err_d;
        end
    end
endmodule
